// File: rtl/gram_pkg.sv
// Shared definitions for the Gram-matrix result collector: select codes,
// FSM state encodings, packed-entry indices and the symmetric index map.
package gram_pkg;

  localparam int unsigned N_ENTRIES = 10;
  localparam int unsigned IDX_W     = 4;
  localparam int unsigned SEL_W     = 3;
  localparam int unsigned ST_W      = 2;

  // Select codes (MAC1 and MAC2 share the numeric space but address disjoint entries)
  localparam logic [SEL_W-1:0] SEL_NONE = 3'b111;
  localparam logic [SEL_W-1:0] SEL1_B12 = 3'b000;
  localparam logic [SEL_W-1:0] SEL1_B13 = 3'b001;
  localparam logic [SEL_W-1:0] SEL1_B14 = 3'b010;
  localparam logic [SEL_W-1:0] SEL1_B23 = 3'b011;
  localparam logic [SEL_W-1:0] SEL1_B34 = 3'b100;
  localparam logic [SEL_W-1:0] SEL2_B11 = 3'b000;
  localparam logic [SEL_W-1:0] SEL2_B22 = 3'b001;
  localparam logic [SEL_W-1:0] SEL2_B33 = 3'b010;
  localparam logic [SEL_W-1:0] SEL2_B44 = 3'b011;
  localparam logic [SEL_W-1:0] SEL2_B24 = 3'b100;

  // FSM state encodings
  localparam logic [ST_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [ST_W-1:0] ST_COLLECT = 2'd1;
  localparam logic [ST_W-1:0] ST_STREAM  = 2'd2;

  // Upper-triangle entry indices, row-major
  localparam logic [IDX_W-1:0] E_B11 = 4'd0;
  localparam logic [IDX_W-1:0] E_B12 = 4'd1;
  localparam logic [IDX_W-1:0] E_B13 = 4'd2;
  localparam logic [IDX_W-1:0] E_B14 = 4'd3;
  localparam logic [IDX_W-1:0] E_B22 = 4'd4;
  localparam logic [IDX_W-1:0] E_B23 = 4'd5;
  localparam logic [IDX_W-1:0] E_B24 = 4'd6;
  localparam logic [IDX_W-1:0] E_B33 = 4'd7;
  localparam logic [IDX_W-1:0] E_B34 = 4'd8;
  localparam logic [IDX_W-1:0] E_B44 = 4'd9;

  // Codes 000..100 address an entry; 111 is idle; 101/110 are illegal
  function automatic logic sel_legal(input logic [SEL_W-1:0] sel);
    return sel <= 3'b100;
  endfunction

  function automatic logic sel_illegal(input logic [SEL_W-1:0] sel);
    return (sel == 3'b101) || (sel == 3'b110);
  endfunction

  function automatic logic [IDX_W-1:0] mac1_entry(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL1_B12: return E_B12;
      SEL1_B13: return E_B13;
      SEL1_B14: return E_B14;
      SEL1_B23: return E_B23;
      SEL1_B34: return E_B34;
      default:  return E_B12;
    endcase
  endfunction

  function automatic logic [IDX_W-1:0] mac2_entry(input logic [SEL_W-1:0] sel);
    case (sel)
      SEL2_B11: return E_B11;
      SEL2_B22: return E_B22;
      SEL2_B33: return E_B33;
      SEL2_B44: return E_B44;
      SEL2_B24: return E_B24;
      default:  return E_B11;
    endcase
  endfunction

  // (row, col) -> packed entry, mirroring the lower triangle onto the upper
  function automatic logic [IDX_W-1:0] sym_index(input logic [1:0] row, input logic [1:0] col);
    logic [1:0] lo;
    logic [1:0] hi;
    lo = (row < col) ? row : col;
    hi = (row < col) ? col : row;
    case ({lo, hi})
      4'b00_00: return E_B11;
      4'b00_01: return E_B12;
      4'b00_10: return E_B13;
      4'b00_11: return E_B14;
      4'b01_01: return E_B22;
      4'b01_10: return E_B23;
      4'b01_11: return E_B24;
      4'b10_10: return E_B33;
      4'b10_11: return E_B34;
      4'b11_11: return E_B44;
      default:  return E_B11;
    endcase
  endfunction

endpackage

// File: rtl/gram_result_collector_if.sv
// Bus bundle between the MAC datapath / host stream and the result collector.
interface gram_result_collector_if #(
  parameter int unsigned DATA_W = 16
);
  logic              start;
  logic [DATA_W-1:0] mac1_out;
  logic [DATA_W-1:0] mac2_out;
  logic [2:0]        mac1_output_sel;
  logic [2:0]        mac2_output_sel;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        out_row;
  logic [1:0]        out_col;
  logic              out_last;
  logic              busy;
  logic              sel_err;

  modport master (
    output start, mac1_out, mac2_out, mac1_output_sel, mac2_output_sel, out_ready,
    input  out_valid, out_data, out_row, out_col, out_last, busy, sel_err
  );

  modport slave (
    input  start, mac1_out, mac2_out, mac1_output_sel, mac2_output_sel, out_ready,
    output out_valid, out_data, out_row, out_col, out_last, busy, sel_err
  );
endinterface

// File: rtl/gram_sym_index.sv
// Combinational (row, col) -> packed upper-triangle entry index.
module gram_sym_index
  import gram_pkg::*;
(
  input  logic [1:0]       row_i,
  input  logic [1:0]       col_i,
  output logic [IDX_W-1:0] idx_o
);

  // Mirror lookup shared with the package function
  assign idx_o = sym_index(row_i, col_i);

endmodule

// File: rtl/gram_result_collector.sv
// Collects the 10 unique entries of B = A*A^T from MAC1/MAC2 and streams the
// 4x4 matrix row-major over valid/ready.
// Build option: RESULT_UPPER_ONLY_EN streams only the 10 pairs with row <= col.
module gram_result_collector
  import gram_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  gram_result_collector_if.slave bus
);

  logic [ST_W-1:0]      state_q, state_d;
  logic [N_ENTRIES-1:0] mask_q, mask_d;
  logic                 sel_err_q, sel_err_d;
  logic                 out_valid_q, out_valid_d;
  logic                 out_last_q, out_last_d;
  logic [1:0]           row_q, row_d;
  logic [1:0]           col_q, col_d;
  logic [DATA_W-1:0]    out_data_q, out_data_d;
  logic                 busy_q, busy_d;
  logic [DATA_W-1:0]    buf_q [N_ENTRIES];

  logic                 wr1_c, wr2_c;
  logic [IDX_W-1:0]     wr1_idx_c, wr2_idx_c;
  logic [IDX_W-1:0]     rd_idx_c;
  logic [DATA_W-1:0]    rd_data_c;
  logic [1:0]           nxt_row_c, nxt_col_c;

  assign wr1_idx_c = mac1_entry(bus.mac1_output_sel);
  assign wr2_idx_c = mac2_entry(bus.mac2_output_sel);

  // Buffer index for the pair that will be presented next cycle
  gram_sym_index u_rd_index (
    .row_i (row_d),
    .col_i (col_d),
    .idx_o (rd_idx_c)
  );

  // Successor of the current stream pair
  always_comb begin
    nxt_row_c = row_q;
    nxt_col_c = col_q;
`ifdef RESULT_UPPER_ONLY_EN
    if (col_q == 2'd3) begin
      nxt_row_c = 2'(row_q + 2'd1);
      nxt_col_c = 2'(row_q + 2'd1);
    end else begin
      nxt_col_c = 2'(col_q + 2'd1);
    end
`else
    if (col_q == 2'd3) begin
      nxt_row_c = 2'(row_q + 2'd1);
      nxt_col_c = 2'd0;
    end else begin
      nxt_col_c = 2'(col_q + 2'd1);
    end
`endif
  end

  // Next-state, capture and stream-walk logic
  always_comb begin
    state_d     = state_q;
    mask_d      = mask_q;
    sel_err_d   = sel_err_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    row_d       = row_q;
    col_d       = col_q;
    wr1_c       = 1'b0;
    wr2_c       = 1'b0;

    if (bus.start) begin
      state_d     = ST_COLLECT;
      mask_d      = '0;
      sel_err_d   = 1'b0;
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
      row_d       = 2'd0;
      col_d       = 2'd0;
    end else begin
      case (state_q)
        ST_COLLECT: begin
          if (sel_legal(bus.mac1_output_sel)) begin
            wr1_c             = 1'b1;
            mask_d[wr1_idx_c] = 1'b1;
          end
          if (sel_legal(bus.mac2_output_sel)) begin
            wr2_c             = 1'b1;
            mask_d[wr2_idx_c] = 1'b1;
          end
          if (sel_illegal(bus.mac1_output_sel) || sel_illegal(bus.mac2_output_sel)) begin
            sel_err_d = 1'b1;
          end
          if (&mask_d) begin
            state_d     = ST_STREAM;
            out_valid_d = 1'b1;
            out_last_d  = 1'b0;
            row_d       = 2'd0;
            col_d       = 2'd0;
          end
        end
        ST_STREAM: begin
          if (bus.out_ready) begin
            if (out_last_q) begin
              state_d     = ST_IDLE;
              out_valid_d = 1'b0;
              out_last_d  = 1'b0;
            end else begin
              row_d      = nxt_row_c;
              col_d      = nxt_col_c;
              out_last_d = (nxt_row_c == 2'd3) && (nxt_col_c == 2'd3);
            end
          end
        end
        default: ;
      endcase
    end

    busy_d = (state_d != ST_IDLE);
  end

  // Read-through so a capture in the completing cycle reaches the first beat
  always_comb begin
    rd_data_c = buf_q[rd_idx_c];
    if (wr1_c && (wr1_idx_c == rd_idx_c)) rd_data_c = bus.mac1_out;
    if (wr2_c && (wr2_idx_c == rd_idx_c)) rd_data_c = bus.mac2_out;
    out_data_d = (state_d == ST_STREAM) ? rd_data_c : out_data_q;
  end

  // Control and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      mask_q      <= '0;
      sel_err_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      row_q       <= 2'd0;
      col_q       <= 2'd0;
      out_data_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      sel_err_q   <= sel_err_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      row_q       <= row_d;
      col_q       <= col_d;
      out_data_q  <= out_data_d;
      busy_q      <= busy_d;
    end
  end

  // Entry storage; the mask alone tracks validity, so no reset is needed
  always_ff @(posedge clk) begin
    if (wr1_c) buf_q[wr1_idx_c] <= bus.mac1_out;
    if (wr2_c) buf_q[wr2_idx_c] <= bus.mac2_out;
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;
  assign bus.out_row   = row_q;
  assign bus.out_col   = col_q;
  assign bus.out_last  = out_last_q;
  assign bus.busy      = busy_q;
  assign bus.sel_err   = sel_err_q;

endmodule

// File: tb/tb_gram_result_collector.sv
// Scoreboard bench for gram_result_collector: stimulus pushes expected beats,
// a negedge monitor pops and compares on every handshake.
module tb_gram_result_collector;

  localparam int unsigned DATA_W = 16;

  typedef logic [15:0] vals_t [10];
  typedef struct packed {
    logic [15:0] data;
    logic [1:0]  row;
    logic [1:0]  col;
    logic        last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  gram_result_collector_if #(.DATA_W(DATA_W)) bus ();

  gram_result_collector #(.DATA_W(DATA_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [1:0] sx_row, sx_col;
  logic [3:0] sx_idx;
  gram_sym_index u_sx (.row_i(sx_row), .col_i(sx_col), .idx_o(sx_idx));

  // Hand-derived tables: (row,col) -> entry, and select code -> entry per MAC
  int sym_tbl [16] = '{0, 1, 2, 3,  1, 4, 5, 6,  2, 5, 7, 8,  3, 6, 8, 9};
  int m1_ent  [5]  = '{1, 2, 3, 5, 8};
  int m2_ent  [5]  = '{0, 4, 7, 9, 6};

  beat_t exp_q [$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  task automatic present(input logic [2:0] s1, input logic [15:0] d1,
                         input logic [2:0] s2, input logic [15:0] d2);
    bus.mac1_output_sel = s1;
    bus.mac1_out        = d1;
    bus.mac2_output_sel = s2;
    bus.mac2_out        = d2;
    tick();
    bus.mac1_output_sel = 3'b111;
    bus.mac2_output_sel = 3'b111;
  endtask

  // Dual-write cycles: code k on both MACs for k in [first, first+count)
  task automatic load_codes(input vals_t v, input int first, input int count);
    for (int k = first; k < first + count; k++) begin
      present(3'(k), v[m1_ent[k]], 3'(k), v[m2_ent[k]]);
    end
  endtask

  task automatic push_expect(input vals_t v, input int nbeats);
    int n;
    beat_t b;
    n = 0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
`ifdef RESULT_UPPER_ONLY_EN
        if (r > c) continue;
`endif
        if (n < nbeats) begin
          b.data = v[sym_tbl[r*4 + c]];
          b.row  = 2'(r);
          b.col  = 2'(c);
          b.last = (r == 3) && (c == 3);
          exp_q.push_back(b);
        end
        n++;
      end
    end
  endtask

  task automatic wait_drain(input string name, input int budget);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || bus.busy) && n < budget) begin
      tick();
      n++;
    end
    check(name, 32'(n < budget), 32'd1);
  endtask

  // Monitor: compares each handshake beat and checks hold during backpressure
  beat_t held;
  beat_t got;
  beat_t want;
  logic  stall_prev = 1'b0;
  always @(negedge clk) begin
    if (rst) begin
      stall_prev = 1'b0;
    end else begin
      got = '{bus.out_data, bus.out_row, bus.out_col, bus.out_last};
      if (stall_prev) begin
        check("hold_valid", 32'(bus.out_valid), 32'd1);
        check("hold_beat", 32'(got), 32'(held));
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_beat: got row=%0d col=%0d data=0x%0h, expected no beat",
                   bus.out_row, bus.out_col, bus.out_data);
        end else begin
          want = exp_q.pop_front();
          check("beat_data", 32'(got.data), 32'(want.data));
          check("beat_row",  32'(got.row),  32'(want.row));
          check("beat_col",  32'(got.col),  32'(want.col));
          check("beat_last", 32'(got.last), 32'(want.last));
        end
      end
      stall_prev = bus.out_valid && !bus.out_ready && !bus.start;
      held = got;
    end
  end

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"},   32'(bus.out_valid), 32'd0);
    check({tag, "_data"},    32'(bus.out_data),  32'd0);
    check({tag, "_row"},     32'(bus.out_row),   32'd0);
    check({tag, "_col"},     32'(bus.out_col),   32'd0);
    check({tag, "_last"},    32'(bus.out_last),  32'd0);
    check({tag, "_busy"},    32'(bus.busy),      32'd0);
    check({tag, "_sel_err"}, 32'(bus.sel_err),   32'd0);
  endtask

  vals_t v1, v2, v5, v6;

  initial begin
    bus.start           = 1'b0;
    bus.mac1_out        = '0;
    bus.mac2_out        = '0;
    bus.mac1_output_sel = 3'b111;
    bus.mac2_output_sel = 3'b111;
    bus.out_ready       = 1'b0;
    for (int i = 0; i < 10; i++) begin
      v1[i] = 16'(i + 1);
      v2[i] = 16'(16'h0100 + i);
      v5[i] = 16'(16'h0200 + i);
      v6[i] = 16'(16'h0300 + i);
    end
    v2[0] = 16'h0055;
    v2[1] = 16'h00AA;

    #1;
    check_reset_outputs("reset");

    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        sx_row = 2'(r);
        sx_col = 2'(c);
        #1;
        check("sym_index", 32'(sx_idx), 32'(sym_tbl[r*4 + c]));
      end
    end

    tick();
    rst = 1'b0;

    // Full collect and stream with values 1..10
    bus.out_ready = 1'b1;
    do_start();
    check("busy_after_start", 32'(bus.busy), 32'd1);
    load_codes(v1, 0, 4);
    check("valid_before_complete", 32'(bus.out_valid), 32'd0);
    push_expect(v1, 16);
    load_codes(v1, 4, 1);
    check("valid_after_complete", 32'(bus.out_valid), 32'd1);
    wait_drain("drain_full", 40);
    check("busy_after_stream", 32'(bus.busy), 32'd0);
    check("valid_after_stream", 32'(bus.out_valid), 32'd0);

    // Dual write in one cycle: b11=0x55, b12=0xAA
    do_start();
    load_codes(v2, 0, 4);
    push_expect(v2, 16);
    load_codes(v2, 4, 1);
    wait_drain("drain_dual", 40);

    // Backpressure for 5 cycles on the (0,3) beat
    bus.out_ready = 1'b0;
    do_start();
    load_codes(v1, 0, 4);
    push_expect(v1, 16);
    load_codes(v1, 4, 1);
    bus.out_ready = 1'b1;
    tick();
    tick();
    tick();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      check("bp_valid", 32'(bus.out_valid), 32'd1);
      check("bp_data",  32'(bus.out_data),  32'd4);
      check("bp_row",   32'(bus.out_row),   32'd0);
      check("bp_col",   32'(bus.out_col),   32'd3);
      tick();
    end
    bus.out_ready = 1'b1;
    wait_drain("drain_bp", 40);

    // Illegal select codes set sel_err but capture nothing
    do_start();
    present(3'b101, 16'h0077, 3'b111, 16'h0000);
    check("sel_err_set", 32'(bus.sel_err), 32'd1);
    present(3'b111, 16'h0000, 3'b110, 16'h0066);
    check("sel_err_sticky", 32'(bus.sel_err), 32'd1);
    load_codes(v1, 0, 3);
    present(3'd3, v1[5], 3'd4, v1[6]);
    present(3'd4, v1[8], 3'b111, 16'h0000);
    for (int i = 0; i < 3; i++) begin
      check("nine_entries_no_stream", 32'(bus.out_valid), 32'd0);
      tick();
    end
    push_expect(v1, 16);
    present(3'b111, 16'h0000, 3'd3, v1[9]);
    wait_drain("drain_illegal", 40);
    check("sel_err_after_stream", 32'(bus.sel_err), 32'd1);

    // Abort by start while the 8th beat is presented
    do_start();
    check("sel_err_cleared", 32'(bus.sel_err), 32'd0);
    load_codes(v5, 0, 4);
    push_expect(v5, 8);
    load_codes(v5, 4, 1);
    for (int i = 0; i < 7; i++) tick();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_busy", 32'(bus.busy), 32'd1);
    check("abort_queue", 32'(exp_q.size()), 32'd0);
    load_codes(v6, 0, 4);
    tick();
    tick();
    check("abort_no_stream", 32'(bus.out_valid), 32'd0);
    push_expect(v6, 16);
    load_codes(v6, 4, 1);
    wait_drain("drain_abort", 40);

    // Reset during collection after 6 entries
    do_start();
    load_codes(v1, 0, 3);
    rst = 1'b1;
    #1;
    check_reset_outputs("midrst");
    tick();
    rst = 1'b0;
    do_start();
    load_codes(v1, 0, 2);
    for (int i = 0; i < 3; i++) tick();
    check("four_entries_no_stream", 32'(bus.out_valid), 32'd0);
    check("four_entries_busy", 32'(bus.busy), 32'd1);
    load_codes(v1, 2, 2);
    push_expect(v1, 16);
    load_codes(v1, 4, 1);
    wait_drain("drain_after_rst", 40);

    tick();
    check("queue_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
